// File: rtl/uart_rx_packer_if.sv
// rtl/uart_rx_packer_if.sv - core RX side and CPU read side of the UART receive packer
interface uart_rx_packer_if #(
    parameter int AW = 3
);
    logic [7:0]    rx_q;
    logic          rx_dv;
    logic          rx_fe;
    logic          rx_ove;
    logic          rx_rd;
    logic          mode;
    logic          rd;
    logic [31:0]   q;
    logic          dv;
    logic          qfe;
    logic          ove;
    logic [AW:0]   count;
    logic          tmo;

    modport master (
        output rx_q, rx_dv, rx_fe, rx_ove, mode, rd,
        input  rx_rd, q, dv, qfe, ove, count, tmo
    );

    modport slave (
        input  rx_q, rx_dv, rx_fe, rx_ove, mode, rd,
        output rx_rd, q, dv, qfe, ove, count, tmo
    );
endinterface

// File: rtl/uart_rx_packer.sv
// rtl/uart_rx_packer.sv - packs UART RX bytes into 32-bit words and buffers them in a FIFO
// RXTIMEOUT_EN: flushes a partial burst word after TIMEOUT idle cycles.
module uart_rx_packer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_packer_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH != (1 << AW) || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_rx_packer: DEPTH must equal 2**AW and TIMEOUT must be positive");
    end

    logic        rx_rd_r;
    logic [1:0]  cnt;
    logic        modew;
    logic [23:0] acc;
    logic        accfe;
    logic        push_r;
    logic [31:0] word_r;
    logic        wfe_r;
    logic        wtmo_r;

    logic        cap;
    logic        m_eff;

    logic [33:0] mem [DEPTH];
    logic [AW:0] wrptr;
    logic [AW:0] rdptr;
    logic [AW:0] count;
    logic        dv;
    logic        pop;
    logic        full;
    logic        do_push;
    logic        drop;
    logic        ove_r;
    logic [33:0] head;

    // rx_rd blocks a second capture while the core is still clearing its dv
    assign cap   = bus.rx_dv & ~rx_rd_r;
    assign m_eff = (cnt == 2'd0) ? bus.mode : modew;

`ifdef RXTIMEOUT_EN
    logic [31:0] idle;
    logic        flush;

    assign flush = ~cap && (cnt != 2'd0) && (idle == 32'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || cap || flush) begin
            idle <= '0;
        end else if (cnt != 2'd0) begin
            idle <= idle + 32'd1;
        end
    end
`else
    logic flush;
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rd_r <= 1'b0;
            cnt     <= 2'd0;
            modew   <= 1'b0;
            acc     <= '0;
            accfe   <= 1'b0;
            push_r  <= 1'b0;
            word_r  <= '0;
            wfe_r   <= 1'b0;
            wtmo_r  <= 1'b0;
        end else begin
            rx_rd_r <= cap;
            push_r  <= 1'b0;
            wtmo_r  <= 1'b0;
            if (cap) begin
                if (cnt == 2'd0) begin
                    modew <= bus.mode;
                end
                if (!m_eff) begin
                    word_r <= {24'h0, bus.rx_q};
                    wfe_r  <= bus.rx_fe;
                    push_r <= 1'b1;
                end else if (cnt == 2'd3) begin
                    word_r <= {bus.rx_q, acc};
                    wfe_r  <= accfe | bus.rx_fe;
                    push_r <= 1'b1;
                    cnt    <= 2'd0;
                end else begin
                    // first byte clears the upper lanes so a flushed partial word reads zero there
                    if (cnt == 2'd0) begin
                        acc   <= {16'h0, bus.rx_q};
                        accfe <= bus.rx_fe;
                    end else begin
                        acc[{cnt, 3'b000} +: 8] <= bus.rx_q;
                        accfe <= accfe | bus.rx_fe;
                    end
                    cnt <= cnt + 2'd1;
                end
            end else if (flush) begin
                word_r <= {8'h0, acc};
                wfe_r  <= accfe;
                wtmo_r <= 1'b1;
                push_r <= 1'b1;
                cnt    <= 2'd0;
            end
        end
    end

    assign count   = wrptr - rdptr;
    assign dv      = (count != '0);
    assign pop     = bus.rd & dv;
    assign full    = (count == FULL_CNT);
    assign do_push = push_r & (~full | pop);
    assign drop    = push_r & full & ~pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wrptr[AW-1:0]] <= {wfe_r, wtmo_r, word_r};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
            ove_r <= 1'b0;
        end else begin
            if (do_push) begin
                wrptr <= wrptr + 1'b1;
            end
            if (pop) begin
                rdptr <= rdptr + 1'b1;
            end
            if ((cap & bus.rx_ove) | drop) begin
                ove_r <= 1'b1;
            end else if (pop) begin
                ove_r <= 1'b0;
            end
        end
    end

    assign head      = mem[rdptr[AW-1:0]];
    assign bus.rx_rd = rx_rd_r;
    assign bus.q     = head[31:0];
    assign bus.qfe   = dv & head[33];
    assign bus.tmo   = dv & head[32];
    assign bus.dv    = dv;
    assign bus.ove   = ove_r;
    assign bus.count = count;
endmodule

// File: tb/tb_uart_rx_packer.sv
// tb/tb_uart_rx_packer.sv - directed self-checking bench for uart_rx_packer
module tb_uart_rx_packer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_rx_packer_if #(.AW(3)) bus ();

    uart_rx_packer #(.DEPTH(8), .AW(3), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one byte from the core: dv held until the acknowledge edge, then dropped
    task automatic send(input logic [7:0] b, input logic fe, input logic ov, input logic pop_with);
        @(negedge clk);
        bus.rx_q   = b;
        bus.rx_fe  = fe;
        bus.rx_ove = ov;
        bus.rx_dv  = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rx_rd_pulse", 32'(bus.rx_rd), 32'd1);
        bus.rx_dv  = 1'b0;
        bus.rx_fe  = 1'b0;
        bus.rx_ove = 1'b0;
        bus.rd     = pop_with;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        check_eq("rx_rd_end", 32'(bus.rx_rd), 32'd0);
    endtask

    task automatic pop_word();
        @(negedge clk);
        bus.rd = 1'b1;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.rx_q = 8'h0; bus.rx_dv = 1'b0; bus.rx_fe = 1'b0; bus.rx_ove = 1'b0;
        bus.mode = 1'b0; bus.rd = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();
        #1;
        check_eq("rst_rx_rd", 32'(bus.rx_rd), 32'd0);
        check_eq("rst_dv",    32'(bus.dv),    32'd0);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_ove",   32'(bus.ove),   32'd0);
        check_eq("rst_qfe",   32'(bus.qfe),   32'd0);
        check_eq("rst_tmo",   32'(bus.tmo),   32'd0);

        // normal mode
        send(8'h41, 1'b0, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0, 1'b0);
        check_eq("n_q0",    bus.q, 32'h00000041);
        check_eq("n_dv",    32'(bus.dv), 32'd1);
        check_eq("n_count", 32'(bus.count), 32'd2);
        pop_word();
        check_eq("n_q1", bus.q, 32'h00000042);
        pop_word();
        check_eq("n_empty", 32'(bus.dv), 32'd0);

        // burst mode
        bus.mode = 1'b1;
        send(8'h11, 1'b0, 1'b0, 1'b0);
        check_eq("b_cnt1", 32'(bus.count), 32'd0);
        send(8'h22, 1'b0, 1'b0, 1'b0);
        check_eq("b_cnt2", 32'(bus.count), 32'd0);
        send(8'h33, 1'b0, 1'b0, 1'b0);
        check_eq("b_cnt3", 32'(bus.count), 32'd0);
        send(8'h44, 1'b0, 1'b0, 1'b0);
        check_eq("b_count", 32'(bus.count), 32'd1);
        check_eq("b_q",     bus.q, 32'h44332211);
        check_eq("b_qfe",   32'(bus.qfe), 32'd0);
        pop_word();

        // mode change mid-word waits for the word to finish
        send(8'hAA, 1'b0, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0, 1'b0);
        bus.mode = 1'b0;
        send(8'hCC, 1'b0, 1'b0, 1'b0);
        check_eq("ms_nopush", 32'(bus.count), 32'd0);
        send(8'hDD, 1'b0, 1'b0, 1'b0);
        check_eq("ms_q", bus.q, 32'hDDCCBBAA);
        pop_word();
        send(8'h01, 1'b0, 1'b0, 1'b0);
        check_eq("ms_q_norm", bus.q, 32'h00000001);
        check_eq("ms_count",  32'(bus.count), 32'd1);
        pop_word();

        // overflow drop, then full with a coincident pop
        for (int i = 0; i < 8; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
        check_eq("f_full", 32'(bus.count), 32'd8);
        check_eq("f_ove0", 32'(bus.ove),   32'd0);
        send(8'hF9, 1'b0, 1'b0, 1'b0);
        check_eq("f_cnt_drop", 32'(bus.count), 32'd8);
        check_eq("f_ove1",     32'(bus.ove),   32'd1);
        check_eq("f_head",     bus.q,          32'h00000000);
        pop_word();
        check_eq("f_ove_clr", 32'(bus.ove),   32'd0);
        check_eq("f_cnt7",    32'(bus.count), 32'd7);
        send(8'h08, 1'b0, 1'b0, 1'b0);
        check_eq("f_cnt8", 32'(bus.count), 32'd8);
        send(8'hFA, 1'b0, 1'b0, 1'b1);
        check_eq("f_cnt_keep", 32'(bus.count), 32'd8);
        check_eq("f_ove_keep", 32'(bus.ove),   32'd0);
        for (int i = 2; i <= 9; i++) begin
            check_eq("f_drain", bus.q, (i == 9) ? 32'h000000FA : 32'(i));
            pop_word();
        end
        check_eq("f_empty", 32'(bus.dv), 32'd0);

        // framing error on one byte of a burst word, then core overrun
        bus.mode = 1'b1;
        send(8'h10, 1'b0, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0, 1'b0);
        send(8'h30, 1'b1, 1'b0, 1'b0);
        send(8'h40, 1'b0, 1'b0, 1'b0);
        send(8'h50, 1'b0, 1'b0, 1'b0);
        send(8'h60, 1'b0, 1'b0, 1'b0);
        send(8'h70, 1'b0, 1'b0, 1'b0);
        send(8'h80, 1'b0, 1'b0, 1'b0);
        check_eq("fe_q0",   bus.q, 32'h40302010);
        check_eq("fe_qfe0", 32'(bus.qfe), 32'd1);
        pop_word();
        check_eq("fe_q1",   bus.q, 32'h80706050);
        check_eq("fe_qfe1", 32'(bus.qfe), 32'd0);
        pop_word();
        bus.mode = 1'b0;
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        check_eq("ov_set", 32'(bus.ove), 32'd1);
        pop_word();
        check_eq("ov_clr", 32'(bus.ove), 32'd0);

`ifdef RXTIMEOUT_EN
        begin
            int waited = 0;
            bus.mode = 1'b1;
            send(8'h55, 1'b0, 1'b0, 1'b0);
            send(8'h66, 1'b0, 1'b0, 1'b0);
            while (!bus.dv && waited < 60) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check_eq("to_seen",  32'(waited > 10 && waited < 20), 32'd1);
            check_eq("to_q",     bus.q, 32'h00006655);
            check_eq("to_tmo",   32'(bus.tmo), 32'd1);
            pop_word();
        end
`else
        bus.mode = 1'b1;
        send(8'h55, 1'b0, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("nto_wait", 32'(bus.count), 32'd0);
        check_eq("nto_tmo",  32'(bus.tmo),   32'd0);
        send(8'h77, 1'b0, 1'b0, 1'b0);
        send(8'h88, 1'b0, 1'b0, 1'b0);
        check_eq("nto_q", bus.q, 32'h88776655);
        pop_word();
`endif

        // reset mid-word discards the partial word and FIFO contents
        bus.mode = 1'b1;
        send(8'h0E, 1'b0, 1'b0, 1'b0);
        send(8'h0E, 1'b0, 1'b0, 1'b0);
        bus.mode = 1'b0;
        send(8'hEE, 1'b0, 1'b0, 1'b0);
        bus.mode = 1'b1;
        send(8'h55, 1'b0, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b0, 1'b0);
        do_reset();
        #1;
        check_eq("mr_count", 32'(bus.count), 32'd0);
        check_eq("mr_dv",    32'(bus.dv),    32'd0);
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0, 1'b0);
        check_eq("mr_nopush", 32'(bus.count), 32'd0);
        send(8'h03, 1'b0, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0, 1'b0);
        check_eq("mr_count1", 32'(bus.count), 32'd1);
        check_eq("mr_q",      bus.q, 32'h04030201);
        check_eq("mr_tmo",    32'(bus.tmo), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
